// File: rtl/spin_input_accum.sv
// spin_input_accum: turns host mouse / analog-stick motion into the 4-bit
// absolute spinner angle. Motion collects in a saturating residue, and the
// angle advances only on frame ticks, by at most MAX_STEP per tick.
module spin_input_accum #(
    parameter int SENS_SHIFT = 2,
    parameter int MAX_STEP   = 3,
    parameter int RESID_MAX  = 511,
    parameter int DEADZONE   = 16
) (
    input  logic              clock_40,
    input  logic              reset,
    input  logic signed [8:0] mouse_x,
    input  logic              mouse_strobe,
    input  logic signed [7:0] ana_x,
    input  logic [1:0]        src_sel,
    input  logic              ctc_zc_to_2,
    output logic [3:0]        spin_angle,
    output logic              spin_dir,
    output logic              step_pulse
);

    localparam logic [1:0]        SRC_MOUSE = 2'd1;
    localparam logic [1:0]        SRC_ANA   = 2'd2;
    localparam logic signed [11:0] SAT_HI   = 12'(RESID_MAX);
    localparam logic signed [11:0] SAT_LO   = 12'(-RESID_MAX);
    localparam logic signed [11:0] Q_HI     = 12'(MAX_STEP);
    localparam logic signed [11:0] Q_LO     = 12'(-MAX_STEP);
    localparam logic signed [3:0]  STEP_HI  = 4'(MAX_STEP);
    localparam logic signed [3:0]  STEP_LO  = 4'(-MAX_STEP);
    localparam logic signed [11:0] BIAS     = 12'((1 << SENS_SHIFT) - 1);
    localparam logic [8:0]         DZ       = 9'(DEADZONE);
    localparam logic [8:0]         MAG_HI   = 9'(MAX_STEP);

    logic               vs_d;
    logic [1:0]         src_d;
    logic signed [10:0] resid;
    logic signed [10:0] resid_nxt;

    logic               tick;
    logic               src_chg;
    logic signed [11:0] r12;
    logic signed [11:0] biased;
    logic signed [11:0] q;
    logic signed [3:0]  mouse_step;
    logic signed [8:0]  ax9;
    logic [8:0]         m;
    logic [8:0]         amag;
    logic signed [3:0]  ana_step;
    logic signed [3:0]  step;
    logic signed [3:0]  mstep;
    logic signed [11:0] sum;

    assign tick    = ctc_zc_to_2 & ~vs_d;
    assign src_chg = (src_sel != src_d);

    // Step selection and next residue; division truncates toward zero by
    // biasing negative residues before the arithmetic shift.
    always_comb begin
        r12        = {resid[10], resid};
        biased     = r12 + (resid[10] ? BIAS : 12'sd0);
        q          = biased >>> SENS_SHIFT;
        mouse_step = 4'sd0;
        if (q > Q_HI)      mouse_step = STEP_HI;
        else if (q < Q_LO) mouse_step = STEP_LO;
        else               mouse_step = q[3:0];

        ax9      = {ana_x[7], ana_x};
        m        = ax9[8] ? 9'(-ax9) : 9'(ax9);
        amag     = 9'd0;
        ana_step = 4'sd0;
        if (m >= DZ) begin
            amag = 9'd1 + ((m - DZ) >> 5);
            if (amag > MAG_HI) amag = MAG_HI;
            ana_step = ana_x[7] ? -$signed(amag[3:0]) : $signed(amag[3:0]);
        end

        step = 4'sd0;
        if (tick) begin
            if (src_sel == SRC_MOUSE)    step = mouse_step;
            else if (src_sel == SRC_ANA) step = ana_step;
        end
        mstep = (src_sel == SRC_MOUSE) ? step : 4'sd0;

        sum = r12 - ({{8{mstep[3]}}, mstep} <<< SENS_SHIFT)
                  + (mouse_strobe ? {{3{mouse_x[8]}}, mouse_x} : 12'sd0);

        resid_nxt = resid;
        if (src_chg)                 resid_nxt = 11'sd0;
        else if (src_sel == SRC_MOUSE) begin
            if (sum > SAT_HI)        resid_nxt = SAT_HI[10:0];
            else if (sum < SAT_LO)   resid_nxt = SAT_LO[10:0];
            else                     resid_nxt = sum[10:0];
        end
        else if (src_sel == SRC_ANA) resid_nxt = 11'sd0;
    end

    // Edge detector, source tracker, residue and angle state.
    always_ff @(posedge clock_40 or posedge reset) begin
        if (reset) begin
            vs_d       <= 1'b0;
            src_d      <= 2'd0;
            resid      <= 11'sd0;
            spin_angle <= 4'd0;
            spin_dir   <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            vs_d       <= ctc_zc_to_2;
            src_d      <= src_sel;
            resid      <= resid_nxt;
            step_pulse <= (step != 4'sd0);
            if (step != 4'sd0) begin
                spin_angle <= spin_angle + step;
                spin_dir   <= ~step[3];
            end
        end
    end

endmodule

// File: tb/tb_spin_input_accum.sv
// Bench for spin_input_accum: directed stimulus pushes expected angle steps
// into a scoreboard, a monitor pops one entry per step_pulse.
`timescale 1ns/1ps
module tb_spin_input_accum;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic signed [8:0] mouse_x = '0;
    logic              mouse_strobe = 1'b0;
    logic signed [7:0] ana_x = '0;
    logic [1:0]        src_sel = 2'd0;
    logic              ctc = 1'b0;
    logic [3:0]        spin_angle;
    logic              spin_dir;
    logic              step_pulse;

    typedef struct {
        logic [3:0] ang;
        logic       dir;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    spin_input_accum dut (
        .clock_40     (clk),
        .reset        (rst),
        .mouse_x      (mouse_x),
        .mouse_strobe (mouse_strobe),
        .ana_x        (ana_x),
        .src_sel      (src_sel),
        .ctc_zc_to_2  (ctc),
        .spin_angle   (spin_angle),
        .spin_dir     (spin_dir),
        .step_pulse   (step_pulse)
    );

    always #12.5 clk = ~clk;

    // Monitor: every pulse cycle must match the next expected step.
    always @(negedge clk) begin
        if (!rst && step_pulse) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse angle=%0d dir=%0d required=none", spin_angle, spin_dir);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (spin_angle !== e.ang || spin_dir !== e.dir) begin
                    bad++;
                    $display("FAIL step angle=%0d dir=%0d required angle=%0d dir=%0d",
                             spin_angle, spin_dir, e.ang, e.dir);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int v);
        @(posedge clk); #1;
        mouse_x = 9'(v); mouse_strobe = 1'b1;
        @(posedge clk); #1;
        mouse_strobe = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        ctc = 1'b1;
        @(posedge clk); #1;
        ctc = 1'b0;
    endtask

    task automatic tick_exp(input int ang, input bit dir);
        exp_t e;
        e.ang = 4'(ang); e.dir = dir;
        sbq.push_back(e);
        tick();
    endtask

    // Bounded wait for all expected pulses to have been seen.
    task automatic drain(input string name);
        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
        cyc(2);
        chk(name, sbq.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("reset_angle", spin_angle, 0);
        chk("reset_dir",   spin_dir,   0);
        chk("reset_pulse", step_pulse, 0);
        chk("reset_resid", int'(dut.resid), 0);

        // T1
        src_sel = 2'd1; cyc(2);
        strobe(12);
        chk("t1_resid_in", int'(dut.resid), 12);
        tick_exp(3, 1);
        drain("t1_drain");
        chk("t1_resid", int'(dut.resid), 0);

        // T2: angle continues from 3
        strobe(40);
        tick_exp(6, 1);  chk("t2_resid1", int'(dut.resid), 28);
        tick_exp(9, 1);  chk("t2_resid2", int'(dut.resid), 16);
        tick_exp(12, 1); chk("t2_resid3", int'(dut.resid), 4);
        tick_exp(13, 1); chk("t2_resid4", int'(dut.resid), 0);
        tick();
        drain("t2_drain");
        chk("t2_angle_hold", spin_angle, 13);

        // T3: negative wrap from 0
        do_reset();
        chk("t3_angle0", spin_angle, 0);
        strobe(-5);
        tick_exp(15, 0);
        drain("t3_drain");
        chk("t3_resid", int'(dut.resid), -1);
        tick();
        drain("t3_drain2");
        chk("t3_angle_hold", spin_angle, 15);
        chk("t3_resid2", int'(dut.resid), -1);

        // T4: saturation, then strobe together with tick
        for (int i = 0; i < 4; i++) strobe(255);
        chk("t4_sat", int'(dut.resid), 511);
        begin
            exp_t e;
            e.ang = 4'd2; e.dir = 1'b1;
            sbq.push_back(e);
            @(posedge clk); #1;
            mouse_x = -9'sd1; mouse_strobe = 1'b1; ctc = 1'b1;
            @(posedge clk); #1;
            mouse_strobe = 1'b0; ctc = 1'b0;
        end
        drain("t4_drain");
        chk("t4_resid", int'(dut.resid), 498);

        // T5: analog sweep (angle starts at 2)
        src_sel = 2'd2; cyc(2);
        chk("t5_resid_clr", int'(dut.resid), 0);
        strobe(100);
        chk("t5_strobe_ign", int'(dut.resid), 0);
        ana_x = 8'sd10;
        for (int i = 0; i < 4; i++) tick();
        drain("t5_dead");
        chk("t5_dead_angle", spin_angle, 2);
        ana_x = 8'sd40;
        for (int i = 0; i < 4; i++) tick_exp(3 + i, 1);
        ana_x = 8'sd80;
        tick_exp(9, 1); tick_exp(12, 1); tick_exp(15, 1); tick_exp(2, 1);
        ana_x = -8'sd128;
        tick_exp(15, 0); tick_exp(12, 0); tick_exp(9, 0); tick_exp(6, 0);
        drain("t5_drain");

        // T6: source change clears residue
        src_sel = 2'd1; cyc(2);
        strobe(100);
        chk("t6_resid", int'(dut.resid), 100);
        src_sel = 2'd2; cyc(2);
        src_sel = 2'd1; cyc(2);
        chk("t6_resid_clr", int'(dut.resid), 0);

        // Held vsync: only one tick
        strobe(40);
        sbq.push_back('{ang: 4'd9, dir: 1'b1});
        @(posedge clk); #1; ctc = 1'b1;
        cyc(6); ctc = 1'b0;
        drain("held_drain");
        chk("held_resid", int'(dut.resid), 28);

        // Hold mode freezes angle and ignores strobes
        src_sel = 2'd0; cyc(2);
        strobe(50);
        tick();
        drain("hold_drain");
        chk("hold_angle", spin_angle, 9);
        chk("hold_resid", int'(dut.resid), 0);

        // Async reset mid-frame after a strobe
        src_sel = 2'd1; cyc(2);
        strobe(20);
        @(posedge clk); #5;
        rst = 1'b1;
        #1;
        chk("arst_angle", spin_angle, 0);
        chk("arst_dir",   spin_dir,   0);
        chk("arst_pulse", step_pulse, 0);
        chk("arst_resid", int'(dut.resid), 0);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        tick();
        drain("arst_drain");
        chk("arst_angle_after", spin_angle, 0);

        chk("final_queue", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
